// File: rtl/ram_stream_reader_if.sv
// Bundle of request, RAM read-port and byte-stream signals for ram_stream_reader.
// The reader itself uses the master view. The environment drives the
// request, RAM data and stream ready through the slave view.
interface ram_stream_reader_if;

    // Request side
    logic         start;
    logic [11:0]  base_addr;
    logic [11:0]  word_count;

    // Vector RAM read port (synchronous read, one cycle latency)
    logic [11:0]  ram_address;
    logic [127:0] ram_q;

    // Byte stream
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready;

    // Status
    logic         busy;
    logic         done;

    modport master (
        input  start,
        input  base_addr,
        input  word_count,
        input  ram_q,
        input  byte_ready,
        output ram_address,
        output byte_out,
        output byte_valid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output base_addr,
        output word_count,
        output ram_q,
        output byte_ready,
        input  ram_address,
        input  byte_out,
        input  byte_valid,
        input  busy,
        input  done
    );

endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a run of 128-bit words from a vector RAM and
// streams each word out little-endian, one byte per valid/ready transfer.
// Every output is a flop, so consumers see glitch-free handshake and status.
module ram_stream_reader (
    input  logic               clk,
    input  logic               reset,
    ram_stream_reader_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [11:0]    addr_q, addr_d;
    logic [11:0]    remaining_q, remaining_d;
    logic [127:0]   buffer_q, buffer_d;
    logic [3:0]     idx_q, idx_d;
    logic [11:0]    ram_address_q, ram_address_d;
    logic [7:0]     byte_out_q, byte_out_d;
    logic           byte_valid_q, byte_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           transfer;
    logic [3:0]     idx_next;
    logic [11:0]    addr_next;

    assign transfer  = byte_valid_q & bus.byte_ready;
    assign idx_next  = idx_q + 4'd1;
    assign addr_next = addr_q + 12'd1;

    // Next-state and next-output logic; outputs are derived from the state
    // being entered so they line up with the registered state.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        buffer_d      = buffer_q;
        idx_d         = idx_q;
        ram_address_d = ram_address_q;
        byte_out_d    = byte_out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.word_count;
                    if (bus.word_count == 12'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        ram_address_d = bus.base_addr;
                        state_d       = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                ram_address_d = addr_q;
                state_d       = ST_WAIT;
            end

            ST_WAIT: begin
                buffer_d   = bus.ram_q;
                idx_d      = 4'd0;
                byte_out_d = bus.ram_q[7:0];
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                if (transfer) begin
                    if (idx_q != 4'd15) begin
                        idx_d      = idx_next;
                        byte_out_d = buffer_q[{idx_next, 3'b000} +: 8];
                    end else begin
                        remaining_d = remaining_q - 12'd1;
                        if (remaining_q != 12'd1) begin
                            addr_d        = addr_next;
                            ram_address_d = addr_next;
                            state_d       = ST_ISSUE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        byte_valid_d = (state_d == ST_SEND);
        busy_d       = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_SEND);
        done_d       = (state_d == ST_DONE);
    end

    // State and output registers; synchronous reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= 12'd0;
            remaining_q   <= 12'd0;
            buffer_q      <= 128'd0;
            idx_q         <= 4'd0;
            ram_address_q <= 12'd0;
            byte_out_q    <= 8'd0;
            byte_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            buffer_q      <= buffer_d;
            idx_q         <= idx_d;
            ram_address_q <= ram_address_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.ram_address = ram_address_q;
    assign bus.byte_out    = byte_out_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: a random-content RAM, requests with
// randomized addresses and ready patterns, and an expected byte stream built
// directly from the RAM contents word by word.
module tb_ram_stream_reader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ram_stream_reader_if bus ();

    ram_stream_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [127:0] mem [0:4095];

    // Synchronous-read RAM: data for the address registered at an edge is
    // available during the following cycle.
    always @(posedge clk) begin
        bus.ram_q <= mem[bus.ram_address];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one request and checks the stream against the RAM contents.
    // ready_mode: 0 = always ready, 1 = toggling, 2 = random.
    task automatic apply_stimulus(input logic [11:0] base, input logic [11:0] count,
                                  input int ready_mode, input bit restart_in_send,
                                  input string tag);
        logic [7:0]   exp_q[$];
        logic [7:0]   got_q[$];
        logic [11:0]  addr_seen[$];
        logic [127:0] word;
        logic [7:0]   prev_byte;
        bit           prev_stall;
        bit           injected;
        int           busy_cycles, done_cnt, done_k, first_valid;
        int           stall_err, bad_valid, mism, addr_mism, budget, k;

        for (int w = 0; w < int'(count); w++) begin
            word = mem[(int'(base) + w) % 4096];
            for (int b = 0; b < 16; b++) exp_q.push_back(word[8*b +: 8]);
        end

        busy_cycles = 0; done_cnt = 0; done_k = -1; first_valid = -1;
        stall_err = 0; bad_valid = 0; mism = 0; addr_mism = 0;
        prev_stall = 1'b0; prev_byte = 8'd0; injected = 1'b0;
        budget = 40 + 60 * int'(count);

        @(negedge clk);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = count;
        @(negedge clk);
        bus.base_addr  = 12'($urandom);
        bus.word_count = 12'($urandom);

        for (k = 0; k < budget; k++) begin
            bus.start = 1'b0;
            case (ready_mode)
                0:       bus.byte_ready = 1'b1;
                1:       bus.byte_ready = ~k[0];
                default: bus.byte_ready = 1'($urandom_range(0, 1));
            endcase

            if (bus.byte_valid && prev_stall && bus.byte_out !== prev_byte) stall_err++;
            if (bus.busy) begin
                busy_cycles++;
                if (addr_seen.size() == 0 || addr_seen[$] != bus.ram_address)
                    addr_seen.push_back(bus.ram_address);
            end
            if (bus.byte_valid && !bus.busy) bad_valid++;
            if (bus.byte_valid && first_valid < 0) first_valid = k;
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bus.byte_valid && bus.byte_ready) got_q.push_back(bus.byte_out);
            prev_stall = bus.byte_valid && !bus.byte_ready;
            prev_byte  = bus.byte_out;

            if (restart_in_send && !injected && bus.byte_valid && got_q.size() == 3) begin
                bus.start      = 1'b1;
                bus.base_addr  = base + 12'd100;
                bus.word_count = 12'd5;
                injected       = 1'b1;
            end

            if (done_k >= 0 && k >= done_k + 3) break;
            @(negedge clk);
        end
        bus.start = 1'b0;

        check_output({tag, " done_pulses"}, done_cnt, 1);
        check_output({tag, " byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
        check_output({tag, " byte_mismatches"}, mism, 0);
        check_output({tag, " stall_changes"}, stall_err, 0);
        check_output({tag, " valid_outside_busy"}, bad_valid, 0);
        if (ready_mode == 0) check_output({tag, " busy_cycles"}, busy_cycles, 18 * int'(count));
        if (count != 12'd0) begin
            check_output({tag, " first_valid_cycle"}, first_valid, 2);
            check_output({tag, " addr_count"}, addr_seen.size(), int'(count));
            for (int i = 0; i < addr_seen.size(); i++)
                if (int'(addr_seen[i]) != (int'(base) + i) % 4096) addr_mism++;
            check_output({tag, " addr_mismatches"}, addr_mism, 0);
        end else begin
            check_output({tag, " done_cycle"}, done_k, 0);
            check_output({tag, " busy_cycles"}, busy_cycles, 0);
            check_output({tag, " first_valid_cycle"}, first_valid, -1);
        end
    endtask

    initial begin
        int n;
        int t;
        int done_seen;
        logic [11:0] rb;

        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[12'h010] = 128'h0F0E0D0C0B0A09080706050403020100;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = 12'd0;
        bus.word_count = 12'd0;
        bus.byte_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_output("reset ram_address", bus.ram_address, 12'd0);
        check_output("reset byte_out", bus.byte_out, 8'd0);
        check_output("reset byte_valid", bus.byte_valid, 1'b0);
        check_output("reset busy", bus.busy, 1'b0);
        check_output("reset done", bus.done, 1'b0);
        reset = 1'b0;

        apply_stimulus(12'h010, 12'd1, 0, 1'b0, "single_word");
        apply_stimulus(12'hFFF, 12'd2, 0, 1'b0, "wrap");
        apply_stimulus(12'($urandom), 12'd1, 1, 1'b0, "toggle_ready");
        apply_stimulus(12'($urandom), 12'd0, 0, 1'b0, "empty");
        apply_stimulus(12'($urandom), 12'd2, 0, 1'b1, "restart_ignored");
        apply_stimulus(12'($urandom), 12'd3, 2, 1'b0, "random_ready");

        // Reset in the middle of word 0, right after its fifth byte.
        rb = 12'($urandom);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.base_addr  = rb;
        bus.word_count = 12'd2;
        bus.byte_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        t = 0;
        while (n < 5 && t < 100) begin
            if (bus.byte_valid && bus.byte_ready) n++;
            if (n < 5) begin
                @(negedge clk);
                t++;
            end
        end
        check_output("midreset bytes_before_reset", n, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("midreset ram_address", bus.ram_address, 12'd0);
        check_output("midreset byte_out", bus.byte_out, 8'd0);
        check_output("midreset byte_valid", bus.byte_valid, 1'b0);
        check_output("midreset busy", bus.busy, 1'b0);
        check_output("midreset done", bus.done, 1'b0);
        reset = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.byte_valid) done_seen++;
        end
        check_output("midreset idle_after_reset", done_seen, 0);

        apply_stimulus(12'($urandom), 12'd2, 0, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), listed in REQ-002..REQ-011.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 start  in  1  request to dump a region; honoured only in IDLE.
REQ-005 base_addr  in  12  first 128-bit word address (RAM port b address space).
REQ-006 word_count  in  12  number of 128-bit words to read; 0 = empty request.
REQ-007 ram_address  out  12  address to the vector RAM read port.
REQ-008 ram_q  in  128  RAM read data; valid in the cycle after the edge that registers ram_address.
REQ-009 byte_out  out  8  streamed data byte.
REQ-010 byte_valid  out  1 / byte_ready  in  1  stream handshake; transfer = byte_valid & byte_ready at rising edge.
REQ-011 busy  out  1  transfer in progress / done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, SEND, DONE.
REQ-013 IDLE: start=1 at edge -> latch base_addr into address counter, word_count into remaining counter; go ISSUE, or DONE if word_count=0.
REQ-014 ISSUE: drive ram_address = address counter; next state WAIT unconditionally.
REQ-015 WAIT: hold ram_address; at end of cycle capture ram_q into 128-bit buffer, byte index := 0; go SEND.
REQ-016 SEND: byte_valid=1; byte_out = buffer[8*idx+7 : 8*idx], byte 0 = ram_q[7:0] first (little-endian).
REQ-017 SEND: byte_out SHALL stay stable while byte_valid=1 and byte_ready=0; no byte dropped or repeated.
REQ-018 SEND: on transfer with idx<15 -> idx+1; on transfer with idx=15 -> remaining-1; if result >0, address+1, go ISSUE; else go DONE.
REQ-019 Address increment SHALL wrap modulo 4096 (0xFFF -> 0x000) without error.
REQ-020 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-021 busy=1 in ISSUE, WAIT, SEND; 0 in IDLE, DONE.
REQ-022 start while not IDLE SHALL be ignored; base_addr/word_count changes after latching SHALL have no effect.
REQ-023 Latency: start sampled at edge N -> ram_address=base_addr after N, byte_valid=1 after edge N+2.
REQ-024 Throughput: 18 cycles per word minimum (ISSUE, WAIT, 16 SEND) with byte_ready held 1.
REQ-025 byte_valid SHALL be 0 outside SEND; total bytes emitted per request = 16*word_count.
REQ-026 ram_address SHALL hold its last value in IDLE and DONE.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE in any state, including mid-SEND, overriding start.
REQ-028 Reset values: ram_address=0, byte_out=0, byte_valid=0, busy=0, done=0, buffer=0, counters=0.
REQ-029 A partially sent word SHALL be discarded on reset; first start after reset begins a fresh request.

Verification
REQ-030 base=0x010, count=1, ram_q=0x0F0E..0100, ready=1 -> ram_address=0x010, bytes 0x00..0x0F in order, done pulse after 16th transfer, 18 busy cycles.
REQ-031 base=0xFFF, count=2 -> ram_address 0xFFF then 0x000, 32 bytes, single done pulse.
REQ-032 count=1, byte_ready toggled 1/0 each cycle -> byte_out stable during stalls, exactly 16 transfers, no duplicates.
REQ-033 count=0, start=1 -> done=1 next cycle, busy never 1, byte_valid never 1.
REQ-034 start pulsed again during SEND with different base -> ignored, original stream completes unchanged.
REQ-035 reset=1 after 5th byte of word 0 -> all outputs reset values next cycle, no done pulse; new start works normally.
